fetch: RTL and testbench
========================

Name: fetch

Overview:
Instruction fetch stage of the pipelined RISC core, sitting directly upstream of the operand-read stage.
- Owns the program counter and drives the instruction-memory address.
- Registers the returned 16-bit instruction into `ir`, which feeds the read stage.
- Handles jump redirects from execute with a one-slot flush, pipeline stalls, and HALT.

Parameters:
- A_SIZE, 10, width of the program counter and instruction-memory address.
- D_SIZE, 32, datapath width. Kept for parameter-list uniformity across stages; unused internally.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  A_SIZE  instruction-memory address (current fetch PC).
- instruction  input  16  instruction-memory read data for `pc`; combinational, valid the same cycle.
- stall  input  1  hazard-unit hold request; freezes this stage.
- jmp_en  input  1  redirect request from execute, already resolved taken.
- jmp_addr  input  A_SIZE  redirect target.
- ir  output  16  registered instruction to the read stage.
- pc_ir  output  A_SIZE  address the current `ir` was fetched from; used by execute for relative jumps.
- ir_valid  output  1  1 = `ir` holds a real fetched instruction; 0 = injected bubble.
- halted  output  1  1 = HALT has been fetched and fetching has stopped.

Behaviour:
- Reset (rst=1 at posedge): pc=0, ir=`NOP (16'h0000), pc_ir=0, ir_valid=0, halted=0.
  - rst has top priority over every other input.
  - Reset mid-stall, mid-halt or mid-jump fully discards that state.
- Per-edge priority: rst > jmp_en > stall > halted > normal.
- Normal (no rst/jmp_en/stall, halted=0):
  - pc <= pc+1, modulo 2^A_SIZE; 2^A_SIZE-1 wraps to 0, no flag.
  - ir <= instruction, pc_ir <= pc, ir_valid <= 1.
- Latency: an instruction at address A appears on `ir` exactly one edge after pc=A was presented.
- Jump (jmp_en=1):
  - pc <= jmp_addr.
  - ir <= `NOP, ir_valid <= 0, pc_ir <= pc_ir (unchanged).
  - halted <= 0. A jump from an older in-flight instruction overrides a younger HALT.
  - jmp_en overrides a simultaneous stall; the flush must happen.
  - The target instruction appears on `ir` one edge after the redirect edge, i.e. exactly one bubble.
  - Back-to-back jmp_en cycles each redirect; the last one wins.
- Stall (stall=1, jmp_en=0): pc, ir, pc_ir, ir_valid and halted all hold. No memory side effects; the fetch address is simply re-presented.
- HALT detection (normal path, instruction[15:9] == `HALT):
  - The HALT instruction itself is registered like any other: ir <= instruction, ir_valid=1, pc_ir <= pc.
  - pc is NOT incremented; halted <= 1 on the same edge.
- Halted (halted=1, no jmp_en/stall):
  - pc holds.
  - Each edge: ir <= `NOP, ir_valid <= 0, pc_ir holds.
  - Exit only via rst or jmp_en.
- Detection is gated on the same edge's path: a HALT word on `instruction` during stall or jmp_en is ignored.
- Outputs ir, pc_ir, ir_valid and halted are registers; pc is a register. No combinational paths from inputs to outputs.

Test Plan:
- Reset then free-run from an instruction ROM holding ADD words at 0..3:
  - pc steps 0,1,2,3 on consecutive edges.
  - ir shows word[0] one edge after reset release, with pc_ir=0 and ir_valid=1.
- Stall held 3 cycles while pc=5:
  - pc, ir and pc_ir frozen for exactly 3 edges.
  - On release, ir=word[5] and pc advances to 6; no instruction is skipped or duplicated.
- jmp_en=1, jmp_addr=10'h120 with stall=1 on the same edge while pc=7:
  - Next edge: pc=0x120, ir=16'h0000, ir_valid=0.
  - Following edge: ir=word[0x120], pc_ir=0x120.
- HALT word at address 4:
  - ir=HALT, ir_valid=1, halted=1, pc stays 4.
  - Subsequent edges give ir=16'h0000 with ir_valid=0.
  - jmp_en to 0x010 clears halted and fetch resumes from 0x010.
- A_SIZE=10 with pc=0x3FF, normal fetch: next pc=0x000 and pc_ir=0x3FF.
- rst asserted while halted=1 and stall=1: next edge gives pc=0, halted=0, ir=16'h0000, ir_valid=0.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, registers the fetched word into ir, and handles
// jump redirects (one-bubble flush), stalls and HALT.
module fetch #(
  parameter int unsigned A_SIZE  = 10,
  parameter int unsigned D_SIZE  = 32,
  parameter logic [6:0]  HALT_OP = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  output logic [A_SIZE-1:0] pc,
  input  logic [15:0]       instruction,
  input  logic              stall,
  input  logic              jmp_en,
  input  logic [A_SIZE-1:0] jmp_addr,
  output logic [15:0]       ir,
  output logic [A_SIZE-1:0] pc_ir,
  output logic              ir_valid,
  output logic              halted
);

  localparam logic [15:0] Nop = 16'h0000;

  // D_SIZE only keeps the parameter list uniform across stages.
  if (D_SIZE == 0) begin : g_dsize_unused
  end

  logic [A_SIZE-1:0] pc_q, pc_d;
  logic [A_SIZE-1:0] pc_ir_q, pc_ir_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic              is_halt;

  assign is_halt = (instruction[15:9] == HALT_OP);

  always_comb begin
    pc_d       = pc_q;
    pc_ir_d    = pc_ir_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    if (jmp_en) begin
      // Redirect wins over stall and clears a younger HALT.
      pc_d       = jmp_addr;
      ir_d       = Nop;
      ir_valid_d = 1'b0;
      halted_d   = 1'b0;
    end else if (stall) begin
      // Hold everything; the same address is simply re-presented.
    end else if (halted_q) begin
      ir_d       = Nop;
      ir_valid_d = 1'b0;
    end else begin
      ir_d       = instruction;
      pc_ir_d    = pc_q;
      ir_valid_d = 1'b1;
      if (is_halt) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      pc_ir_q    <= '0;
      ir_q       <= Nop;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_ir_q    <= pc_ir_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign pc_ir    = pc_ir_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: ROM-backed behavioural model checked every cycle, plus directed literal checks.
module tb_fetch;

  localparam int unsigned A_SIZE  = 10;
  localparam logic [6:0]  HALT_OP = 7'h7F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              jmp_en = 1'b0;
  logic [A_SIZE-1:0] jmp_addr = '0;
  logic [15:0]       instruction;
  logic [A_SIZE-1:0] pc, pc_ir;
  logic [15:0]       ir;
  logic              ir_valid, halted;

  logic [15:0] rom [1024];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [A_SIZE-1:0] m_pc, m_pc_ir;
  logic [15:0]       m_ir, m_word;
  logic              m_valid, m_halted;

  always #5 clk = ~clk;

  assign instruction = rom[pc];

  fetch #(.A_SIZE(A_SIZE), .D_SIZE(32), .HALT_OP(HALT_OP)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction),
    .stall      (stall),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .ir         (ir),
    .pc_ir      (pc_ir),
    .ir_valid   (ir_valid),
    .halted     (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model fetches from its own PC out of the ROM, independent of the DUT address.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_ir = 16'h0000; m_pc_ir = '0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (jmp_en) begin
      m_pc = jmp_addr; m_ir = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_halted) begin
      m_ir = 16'h0000; m_valid = 1'b0;
    end else begin
      m_word  = rom[m_pc];
      m_ir    = m_word;
      m_pc_ir = m_pc;
      m_valid = 1'b1;
      if (m_word[15:9] == HALT_OP) m_halted = 1'b1;
      else m_pc = A_SIZE'((32'(m_pc) + 1) % 1024);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", 32'(pc), 32'(m_pc));
      check("model_ir", 32'(ir), 32'(m_ir));
      check("model_pc_ir", 32'(pc_ir), 32'(m_pc_ir));
      check("model_ir_valid", 32'(ir_valid), 32'(m_valid));
      check("model_halted", 32'(halted), 32'(m_halted));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic j, input logic [A_SIZE-1:0] a);
    @(negedge clk);
    rst = r; stall = s; jmp_en = j; jmp_addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {7'h01, 9'(i)};
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_ir", 32'(ir), 32'h0);
    check("reset_valid", 32'(ir_valid), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);

    cyc(1'b0, 1'b0, 1'b0, '0);
    check("run_pc1", 32'(pc), 32'h1);
    check("run_ir0", 32'(ir), 32'h0200);
    check("run_valid", 32'(ir_valid), 32'h1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    check("run_pc4", 32'(pc), 32'h4);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("run_pc5", 32'(pc), 32'h5);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      check("stall_pc", 32'(pc), 32'h5);
      check("stall_ir", 32'(ir), 32'h0204);
      check("stall_pc_ir", 32'(pc_ir), 32'h4);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("release_ir", 32'(ir), 32'h0205);
    check("release_pc", 32'(pc), 32'h6);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("pre_jump_pc", 32'(pc), 32'h7);

    cyc(1'b0, 1'b1, 1'b1, 10'h120);
    check("jump_pc", 32'(pc), 32'h120);
    check("jump_ir", 32'(ir), 32'h0);
    check("jump_valid", 32'(ir_valid), 32'h0);
    check("jump_pc_ir", 32'(pc_ir), 32'h6);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("target_ir", 32'(ir), 32'h0320);
    check("target_pc_ir", 32'(pc_ir), 32'h120);

    rom[4] = {HALT_OP, 9'h000};
    cyc(1'b0, 1'b0, 1'b1, 10'h004);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("halt_ir", 32'(ir), 32'hFE00);
    check("halt_valid", 32'(ir_valid), 32'h1);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h4);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("halted_ir", 32'(ir), 32'h0);
    check("halted_valid", 32'(ir_valid), 32'h0);
    check("halted_pc", 32'(pc), 32'h4);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("halted_stall", 32'(halted), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 10'h010);
    check("unhalt_flag", 32'(halted), 32'h0);
    check("unhalt_pc", 32'(pc), 32'h10);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("resume_ir", 32'(ir), 32'h0210);
    check("resume_pc", 32'(pc), 32'h11);

    cyc(1'b0, 1'b0, 1'b1, 10'h050);
    cyc(1'b0, 1'b0, 1'b1, 10'h060);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("b2b_ir", 32'(ir), 32'h0260);
    check("b2b_pc", 32'(pc), 32'h61);

    cyc(1'b0, 1'b0, 1'b1, 10'h3FF);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("wrap_pc", 32'(pc), 32'h0);
    check("wrap_pc_ir", 32'(pc_ir), 32'h3FF);
    check("wrap_ir", 32'(ir), 32'h03FF);

    cyc(1'b0, 1'b0, 1'b1, 10'h004);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("halt2_flag", 32'(halted), 32'h1);
    cyc(1'b1, 1'b1, 1'b0, '0);
    check("rst_halt_pc", 32'(pc), 32'h0);
    check("rst_halt_flag", 32'(halted), 32'h0);
    check("rst_halt_ir", 32'(ir), 32'h0);
    check("rst_halt_valid", 32'(ir_valid), 32'h0);

    cyc(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
